// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// fixed XLEN-cycle iteration, one-cycle done pulse, abortable with flush.
module mdu_iterative #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]     count;
   logic [2:0]        op;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   a_hold;
   logic              neg_prod, neg_quo, neg_rem;
   logic              div_zero, div_ovf;

   // ------------------------------------------------------------------
   // Launch-time decode: signedness, magnitudes and special cases
   // ------------------------------------------------------------------
   logic            launch;
   logic            sgn_a, sgn_b;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] abs_a, abs_b;

   always_comb begin
      launch = (state == IDLE) && start && !flush;
      sgn_a  = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV)  || (funct3 == OP_REM);
      sgn_b  = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
      a_neg  = sgn_a && operand_a[XLEN-1];
      b_neg  = sgn_b && operand_b[XLEN-1];
      abs_a  = a_neg ? -operand_a : operand_a;
      abs_b  = b_neg ? -operand_b : operand_b;
   end

   // ------------------------------------------------------------------
   // One iteration of each datapath
   // ------------------------------------------------------------------
   logic [XLEN:0]     mul_add;
   logic [2*XLEN-1:0] prod_step;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   rem_step;
   logic [XLEN-1:0]   quo_step;

   always_comb begin
      // Multiplier bits sit in prod's low half and are shifted out as the
      // partial sum shifts in from the top.
      mul_add   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_b} : '0);
      prod_step = {mul_add, prod[XLEN-1:1]};

      // Remainder stays below the divisor, so XLEN bits hold it after subtract.
      div_shift = {rem, quo[XLEN-1]};
      div_ge    = div_shift >= {1'b0, mag_b};
      rem_step  = div_ge ? (div_shift[XLEN-1:0] - mag_b) : div_shift[XLEN-1:0];
      quo_step  = {quo[XLEN-2:0], div_ge};
   end

   // ------------------------------------------------------------------
   // Final result formed from the last iteration's values
   // ------------------------------------------------------------------
   logic [2*XLEN-1:0] prod_fin;
   logic [XLEN-1:0]   fin_res;

   always_comb begin
      prod_fin = neg_prod ? -prod_step : prod_step;
      fin_res  = '0;
      if (!op[2]) begin
         fin_res = (op[1:0] != 2'b00) ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
      end else if (div_zero) begin
         fin_res = op[1] ? a_hold : '1;
      end else if (div_ovf) begin
         fin_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end else if (op[1]) begin
         fin_res = neg_rem ? -rem_step : rem_step;
      end else begin
         fin_res = neg_quo ? -quo_step : quo_step;
      end
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = CALC;
         CALC: begin
            if (flush)              state_nxt = IDLE;
            else if (count == '0)   state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);
   // A flush landing on the DONE cycle cancels the pulse so the pipeline
   // never retires a killed instruction.
   assign done  = (state == DONE) && !flush;

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         op       <= '0;
         prod     <= '0;
         mag_b    <= '0;
         rem      <= '0;
         quo      <= '0;
         a_hold   <= '0;
         neg_prod <= 1'b0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
         result   <= '0;
      end else if (launch) begin
         count    <= CW'(XLEN-1);
         op       <= funct3;
         prod     <= {{XLEN{1'b0}}, abs_a};
         mag_b    <= abs_b;
         rem      <= '0;
         quo      <= abs_a;
         a_hold   <= operand_a;
         neg_prod <= a_neg ^ b_neg;
         neg_quo  <= a_neg ^ b_neg;
         neg_rem  <= a_neg;
         div_zero <= (operand_b == '0);
         div_ovf  <= funct3[2] && !funct3[0] &&
                     (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
      end else if (state == CALC) begin
         if (flush) begin
            count <= '0;
         end else begin
            count <= count - CW'(1);
            prod  <= prod_step;
            rem   <= rem_step;
            quo   <= quo_step;
            if (count == '0) result <= fin_res;
         end
      end
   end

endmodule
